// File: rtl/musicbox_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : musicbox_pkg                                               |
// | Purpose   : Shared types and helpers for the music box song sequencer: |
// |             ROM entry layout, sequencer state encoding, note decoder.  |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
package musicbox_pkg;

  // Width of one packed song entry {rest, note, beats}
  localparam int unsigned ENTRY_W = 9;

  // A beats field of zero terminates the song
  localparam logic [3:0] END_BEATS = 4'd0;

  // Built-in fallback tune (C, E, G held longer, then end-of-song)
  localparam logic [4*ENTRY_W-1:0] DEFAULT_TUNE = {9'h000, 9'h074, 9'h042, 9'h002};

  typedef struct packed {
    logic       rest;
    logic [3:0] note;
    logic [3:0] beats;
  } note_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_NOTE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_END   = 3'd5
  } seq_state_t;

  // Note index to the tone generator's one-hot switch code
  function automatic logic [15:0] note_onehot(input logic [3:0] note);
    return 16'h0001 << note;
  endfunction

endpackage : musicbox_pkg
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : song_rom                                                   |
// | Purpose   : SONG_LEN x 9-bit song store with a registered (1-cycle)    |
// |             synchronous read. Contents come from the INIT_IMAGE        |
// |             parameter (entry i at bits [9*i +: 9]) so the song can be  |
// |             swapped without touching the sequencer FSM.                |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module song_rom
  import musicbox_pkg::*;
#(
  parameter int unsigned                  SONG_LEN   = 32,
  localparam int unsigned                 ADDR_W     = $clog2(SONG_LEN),
  parameter logic [SONG_LEN*ENTRY_W-1:0]  INIT_IMAGE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [ENTRY_W-1:0] mem [SONG_LEN];
  logic [ENTRY_W-1:0] data_q;

  for (genvar gi = 0; gi < SONG_LEN; gi++) begin : g_mem
    assign mem[gi] = INIT_IMAGE[gi*ENTRY_W +: ENTRY_W];
  end

  // Registered read port: data for addr_i appears one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= mem[addr_i];
    end
  end

  assign data_o = data_q;

endmodule : song_rom
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : song_sequencer                                             |
// | Purpose   : Autonomous melody player in front of the tone generator.   |
// |             Idle: board switches pass through. Playing: steps through  |
// |             song_rom entries, driving one-hot note codes with exact    |
// |             beat timing and a silent articulation gap per entry.       |
// | Options   : SONG_LOOP_EN - when defined, end-of-song restarts at       |
// |             entry 0 instead of returning to idle.                      |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module song_sequencer
  import musicbox_pkg::*;
#(
  parameter int unsigned                  TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned                  GAP_TICKS      = 1_250_000,
  parameter int unsigned                  SONG_LEN       = 32,
  localparam int unsigned                 ADDR_W         = $clog2(SONG_LEN),
  parameter logic [SONG_LEN*ENTRY_W-1:0]  SONG_IMAGE     = (SONG_LEN*ENTRY_W)'(DEFAULT_TUNE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       manual_sw,
  output logic [15:0]       sw_out,
  output logic              playing,
  output logic [ADDR_W-1:0] addr
);

  // Counter wide enough for the longest entry (15 beats), no truncation
  localparam int unsigned      CNT_W = $clog2(15*TICKS_PER_BEAT + 1);
  localparam logic [CNT_W-1:0] TPB_C = CNT_W'(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        sw_q, sw_d;
  logic               play_q, play_d;

  logic [ENTRY_W-1:0] rom_data;
  note_entry_t        entry;
  logic [CNT_W-1:0]   note_len;

  song_rom #(
    .SONG_LEN   (SONG_LEN),
    .INIT_IMAGE (SONG_IMAGE)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  assign entry    = note_entry_t'(rom_data);
  // Sounding part of an entry; FETCH + LOAD + GAP make up the remainder
  assign note_len = CNT_W'(entry.beats) * TPB_C - GAP_C - CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sw_q    <= '0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sw_q    <= sw_d;
      play_q  <= play_d;
    end
  end

  // Next-state and next-output decode; stop overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sw_d    = '0;
    play_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        sw_d   = manual_sw;
        addr_d = '0;
        play_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_FETCH;
          sw_d    = '0;
          play_d  = 1'b1;
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        if (entry.beats == END_BEATS) begin
          state_d = ST_END;
        end else begin
          cnt_d   = note_len;
          sw_d    = entry.rest ? 16'h0000 : note_onehot(entry.note);
          state_d = ST_NOTE;
        end
      end

      ST_NOTE: begin
        // Exit on the last of note_len cycles; "<= 1" also covers a zero load
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = GAP_C - CNT_W'(2);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          sw_d  = sw_q;
        end
      end

      ST_GAP: begin
        // Counts GAP_TICKS-2 down to 0 inclusive, so together with FETCH and
        // LOAD the silence between entries is GAP_TICKS+1 cycles and the
        // FETCH-to-FETCH period is exactly beats*TICKS_PER_BEAT.
        if (cnt_q == '0) begin
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_END: begin
        addr_d = '0;
`ifdef SONG_LOOP_EN
        state_d = ST_FETCH;
`else
        state_d = ST_IDLE;
        play_d  = 1'b0;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        play_d  = 1'b0;
      end
    endcase

    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      sw_d    = '0;
      play_d  = 1'b0;
    end
  end

  assign sw_out  = sw_q;
  assign playing = play_q;
  assign addr    = addr_q;

endmodule : song_sequencer
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_song_sequencer                                          |
// | Purpose   : Self-checking bench for song_sequencer. Two instances: A   |
// |             holds a song with an end marker, B a song that fills the   |
// |             ROM and wraps. Honors SONG_LOOP_EN when defined.           |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module tb_song_sequencer;

  localparam int TPB = 10;
  localparam int GAP = 3;

  // A: note5x2, rest x1, note12x1, END, (unreachable note15)
  localparam logic [71:0] IMG_A = {9'h000, 9'h000, 9'h000, 9'h0F1,
                                   9'h000, 9'h0C1, 9'h131, 9'h052};
  // B: note5x2, rest x1, note0x1, note15x1, then wraps
  localparam logic [35:0] IMG_B = {9'h0F1, 9'h001, 9'h131, 9'h052};

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [15:0] manual_sw;
  logic [15:0] sw_a, sw_b;
  logic        play_a, play_b;
  logic [2:0]  addr_a;
  logic [1:0]  addr_b;

  always #5 clk = ~clk;

  song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .SONG_LEN(8), .SONG_IMAGE(IMG_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .manual_sw(manual_sw),
    .sw_out(sw_a), .playing(play_a), .addr(addr_a));

  song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .SONG_LEN(4), .SONG_IMAGE(IMG_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .manual_sw(manual_sw),
    .sw_out(sw_b), .playing(play_b), .addr(addr_b));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model -------------------------------------
  // Each instance is tracked as (active, entry index, cycle offset within the
  // entry, where offset 0 is the fetch cycle). Outputs follow from the entry
  // timeline: offsets 0,1 silent, then beats*TPB-GAP-1 sounding cycles, then
  // silence until offset beats*TPB-1.
  bit          m_act [2];
  int          m_idx [2];
  int          m_t   [2];
  logic [15:0] exp_sw   [2];
  bit          exp_play [2];
  int          exp_addr [2];

  function automatic logic [8:0] entry_of(input int d, input int i);
    if (d == 0) return IMG_A[i*9 +: 9];
    return IMG_B[i*9 +: 9];
  endfunction

  function automatic int song_len(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic logic [15:0] sound(input int d, input int idx, input int t);
    logic [8:0] e;
    int p;
    e = entry_of(d, idx);
    p = int'(e[3:0]) * TPB;
    if (e[3:0] == 4'd0) return 16'h0000;
    if (t >= 2 && t < p - GAP + 1 && !e[8]) return 16'h0001 << e[7:4];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_idx[d] = 0; m_t[d] = 0;
      exp_sw[d] = 16'h0000; exp_play[d] = 1'b0; exp_addr[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit st, input bit sp, input logic [15:0] man);
    bit was;
    int b;
    was = m_act[d];
    if (m_act[d]) begin
      if (sp) begin
        m_act[d] = 1'b0;
      end else begin
        b = int'(entry_of(d, m_idx[d]) & 9'h00F);
        if (b == 0) begin
          if (m_t[d] < 2) m_t[d]++;
          else begin
`ifdef SONG_LOOP_EN
            m_idx[d] = 0; m_t[d] = 0;
`else
            m_act[d] = 1'b0;
`endif
          end
        end else if (m_t[d] == b*TPB - 1) begin
          m_t[d] = 0;
          m_idx[d] = (m_idx[d] + 1) % song_len(d);
        end else begin
          m_t[d]++;
        end
      end
    end else if (st && !sp) begin
      m_act[d] = 1'b1; m_idx[d] = 0; m_t[d] = 0;
    end
    exp_play[d] = m_act[d];
    exp_addr[d] = m_act[d] ? m_idx[d] : 0;
    if (m_act[d])  exp_sw[d] = sound(d, m_idx[d], m_t[d]);
    else if (was)  exp_sw[d] = 16'h0000;
    else           exp_sw[d] = man;
  endtask

  // Model advances on the same edge the DUT samples its inputs
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d, start, stop, manual_sw);
  end

  // Per-cycle comparison on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("A.sw_out",  sw_a,   exp_sw[0]);
      chk("A.playing", play_a, exp_play[0]);
      chk("A.addr",    addr_a, exp_addr[0]);
      chk("B.sw_out",  sw_b,   exp_sw[1]);
      chk("B.playing", play_b, exp_play[1]);
      chk("B.addr",    addr_b, exp_addr[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset asserted between edges: outputs must clear before the next edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("areset.A.sw_out",  sw_a,   16'h0000);
    chk("areset.A.playing", play_a, 1'b0);
    chk("areset.B.sw_out",  sw_b,   16'h0000);
    chk("areset.B.playing", play_b, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; manual_sw = 16'h0000;
    model_reset();
    #1;
    chk("reset.sw_out",  sw_a,   16'h0000);
    chk("reset.playing", play_a, 1'b0);
    chk("reset.addr",    addr_a, 3'd0);
    cyc(2);
    rst_n = 1'b1;

    // Idle passthrough
    manual_sw = 16'h0040;
    cyc(1);
    chk("idle.pass",    sw_a,   16'h0040);
    chk("idle.playing", play_a, 1'b0);

    // Start: FETCH, LOAD, then note 5 for 16 cycles
    start = 1'b1; cyc(1); start = 1'b0;               // after edge k
    chk("fetch.sw_out",  sw_a,   16'h0000);
    chk("fetch.playing", play_a, 1'b1);
    cyc(1); chk("load.sw_out", sw_a, 16'h0000);       // k+1
    cyc(1); chk("note.first",  sw_a, 16'h0020);       // k+2
    chk("note.B.first", sw_b, 16'h0020);
    cyc(15); chk("note.last",  sw_a, 16'h0020);       // k+17
    cyc(1);  chk("gap.silent", sw_a, 16'h0000);       // k+18
    cyc(2);  chk("next.fetch.addr", addr_a, 3'd1);    // k+20
    cyc(5);  chk("rest.silent", sw_a, 16'h0000);      // k+25
    cyc(5);  chk("rest.advance", addr_a, 3'd2);       // k+30
    cyc(13);                                          // k+43
    chk("B.note15", sw_b, 16'h8000);
`ifdef SONG_LOOP_EN
    chk("end.playing", play_a, 1'b1);
`else
    chk("end.playing", play_a, 1'b0);
`endif
    chk("end.addr", addr_a, 3'd0);
    cyc(1);                                           // k+44
`ifdef SONG_LOOP_EN
    chk("end.sw_out", sw_a, 16'h0000);
`else
    chk("end.sw_out", sw_a, 16'h0040);
`endif
    cyc(6);                                           // k+50
    chk("B.wrap.addr",    addr_b, 2'd0);
    chk("B.wrap.playing", play_b, 1'b1);

    // start+stop together mid-note: stop wins
    cyc(5);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    chk("abort.sw_out",  sw_b,   16'h0000);
    chk("abort.addr",    addr_b, 2'd0);
    chk("abort.playing", play_b, 1'b0);

    // Replay from entry 0
    cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(2);
    chk("replay.A", sw_a, 16'h0020);
    chk("replay.B", sw_b, 16'h0020);
    cyc(5);
    async_reset();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      manual_sw = 16'($urandom);
      r = $urandom_range(0, 199);
      start = (r < 6);
      stop  = (r >= 6 && r < 8) || (r == 0);
      if ($urandom_range(0, 599) == 0) begin
        start = 1'b0; stop = 1'b0;
        async_reset();
      end
    end
    start = 1'b0; stop = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_song_sequencer
`default_nettype wire
